// File: rtl/timer_port_if.sv
// Picoblaze port-bus register interface for the timer: compare value staging,
// control, sticky maskable interrupt with ack handshake, and expiry counter.
module timer_port_if #(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  port_id,
  input  logic        write_strobe,
  input  logic        read_strobe,
  input  logic [7:0]  out_port,
  output logic [7:0]  in_port,
  output logic        interrupt,
  input  logic        interrupt_ack,
  input  logic        timer_interrupt,
  output logic [31:0] timer_count,
  output logic        timer_enable,
  output logic        timer_interrupt_clear
);

  localparam logic [2:0] OFF_B0     = 3'd0;
  localparam logic [2:0] OFF_B1     = 3'd1;
  localparam logic [2:0] OFF_B2     = 3'd2;
  localparam logic [2:0] OFF_B3     = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;
  localparam logic [2:0] OFF_EXP    = 3'd6;

  logic [7:0]  stage0_q, stage0_d;
  logic [7:0]  stage1_q, stage1_d;
  logic [7:0]  stage2_q, stage2_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        pending_q, pending_d;
  logic [7:0]  exp_cnt_q, exp_cnt_d;
  logic        tint_prev_q, tint_prev_d;
  logic        clr_pulse_q, clr_pulse_d;
  logic [7:0]  in_port_q, in_port_d;

  logic [2:0] offset;
  logic       hit;
  logic       wr;
  logic       expiry;
  logic       clear_req;
  logic       exp_rd_clr;

  assign offset = port_id[2:0];
  // Offset 7 of the aligned window is unmapped.
  assign hit    = (port_id[7:3] == BASE_ADDR[7:3]) && (offset != 3'd7);
  assign wr     = write_strobe && hit;
  assign expiry = timer_interrupt && !tint_prev_q;

  always_comb begin
    stage0_d    = stage0_q;
    stage1_d    = stage1_q;
    stage2_d    = stage2_q;
    count_d     = count_q;
    ctrl_d      = ctrl_q;
    tint_prev_d = timer_interrupt;
    in_port_d   = 8'h00;

    if (wr) begin
      case (offset)
        OFF_B0:   stage0_d = out_port;
        OFF_B1:   stage1_d = out_port;
        OFF_B2:   stage2_d = out_port;
        OFF_B3:   count_d  = {out_port, stage2_q, stage1_q, stage0_q};
        OFF_CTRL: ctrl_d   = out_port[1:0];
        default:  ;
      endcase
    end

    // Only an actual pending bit can be cleared; a clear of nothing is silent.
    clear_req   = pending_q && (interrupt_ack ||
                  (wr && offset == OFF_STATUS && out_port[0]));
    clr_pulse_d = clear_req;
    if (expiry)         pending_d = 1'b1;
    else if (clear_req) pending_d = 1'b0;
    else                pending_d = pending_q;

    exp_rd_clr = read_strobe && hit && offset == OFF_EXP;
    if (exp_rd_clr)                      exp_cnt_d = {7'd0, expiry};
    else if (expiry && exp_cnt_q != 8'hFF) exp_cnt_d = exp_cnt_q + 8'd1;
    else                                 exp_cnt_d = exp_cnt_q;

    if (hit) begin
      case (offset)
        OFF_B0:     in_port_d = count_q[7:0];
        OFF_B1:     in_port_d = count_q[15:8];
        OFF_B2:     in_port_d = count_q[23:16];
        OFF_B3:     in_port_d = count_q[31:24];
        OFF_CTRL:   in_port_d = {6'd0, ctrl_q};
        OFF_STATUS: in_port_d = {6'd0, timer_interrupt, pending_q};
        OFF_EXP:    in_port_d = exp_cnt_q;
        default:    in_port_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage0_q    <= 8'h00;
      stage1_q    <= 8'h00;
      stage2_q    <= 8'h00;
      count_q     <= 32'h0;
      ctrl_q      <= 2'b00;
      pending_q   <= 1'b0;
      exp_cnt_q   <= 8'h00;
      tint_prev_q <= 1'b0;
      clr_pulse_q <= 1'b0;
      in_port_q   <= 8'h00;
    end else begin
      stage0_q    <= stage0_d;
      stage1_q    <= stage1_d;
      stage2_q    <= stage2_d;
      count_q     <= count_d;
      ctrl_q      <= ctrl_d;
      pending_q   <= pending_d;
      exp_cnt_q   <= exp_cnt_d;
      tint_prev_q <= tint_prev_d;
      clr_pulse_q <= clr_pulse_d;
      in_port_q   <= in_port_d;
    end
  end

  assign in_port               = in_port_q;
  assign timer_count           = count_q;
  assign timer_enable          = ctrl_q[0];
  assign timer_interrupt_clear = clr_pulse_q;
  assign interrupt             = pending_q && ctrl_q[1];

endmodule
